hv_binarize_collector: RTL and testbench



---
 rtl/hd_pkg.sv | 24 ++
 rtl/hv_sync_fifo.sv | 73 +++++++
 rtl/hv_binarize_collector.sv | 177 +++++++++++++++++
 tb/tb_hv_binarize_collector.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hd_pkg.sv
// ---------------------------------------------------------------------------
// hd_pkg
// Shared definitions for the hyperdimensional encode / search datapath.
// Holds the hypervector geometry constants, the word and address types that
// travel between stages, and the state encoding of the binarize collector.
// No ports; imported by the collector and by the search stage.
// ---------------------------------------------------------------------------
package hd_pkg;

    localparam int DHV_SIZE     = 4000;
    localparam int DIV_SIZE     = 512;
    localparam int HV_WORD_BITS = 16;
    localparam int HV_NUM_WORDS = 250;

    typedef logic [15:0] hv_word_t;
    typedef logic [7:0]  hv_addr_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2
    } collector_state_t;

endpackage

// File: rtl/hv_sync_fifo.sv
// ---------------------------------------------------------------------------
// hv_sync_fifo
// Synchronous show-ahead FIFO. The head entry is presented on rdata_o
// whenever empty_o is low, and it is consumed by pop_i on the next edge.
// A push into a full FIFO is accepted only when a pop happens on the same
// edge; otherwise it is ignored, and the caller detects the drop from full_o.
// flush_i empties the FIFO and takes priority over push and pop.
//
// Ports:
//   clk       clock, all logic on posedge
//   reset_in  synchronous active-high reset
//   flush_i   discard all entries
//   push_i    write wdata_i
//   wdata_i   entry to write
//   pop_i     consume the head entry
//   rdata_o   head entry (only meaningful while empty_o is low)
//   full_o    DEPTH entries held
//   empty_o   no entries held
// ---------------------------------------------------------------------------
module hv_sync_fifo #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_in,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CntW = PtrW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wrPtr_q, rdPtr_q;
    logic [CntW-1:0]  count_q;
    logic             doPush, doPop;

    assign full_o  = (count_q == CntW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign rdata_o = mem_q[rdPtr_q];

    // A full FIFO still takes a push when the head leaves on the same edge.
    assign doPop  = pop_i && !empty_o;
    assign doPush = push_i && (!full_o || doPop);

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap freely.
    always_ff @(posedge clk) begin
        if (reset_in || flush_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
            if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
            case ({doPush, doPop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is not reset; the empty flag keeps stale entries invisible.
    always_ff @(posedge clk) begin
        if (doPush) mem_q[wrPtr_q] <= wdata_i;
    end

endmodule

// File: rtl/hv_binarize_collector.sv
// ---------------------------------------------------------------------------
// hv_binarize_collector
// Captures NUM_LANES signed lane accumulations on each chunk-done pulse,
// sign-binarizes them against THRESH into one hypervector word, tags the word
// with its address and a last flag, and buffers it for the associative-search
// stage. Also keeps the running ones-count of the hypervector and pulses
// hv_done once a complete sample has drained.
//
// Ports:
//   clk           clock, all logic on posedge
//   reset_in      synchronous active-high reset
//   start         one-cycle pulse, begins (or restarts) a sample
//   sums_valid    one-cycle pulse, lane_sums valid
//   lane_sums     packed signed lane sums, lane i at [i*ACC_WIDTH +: ACC_WIDTH]
//   hv_valid      FIFO head valid
//   hv_ready      downstream accepts the head
//   hv_data       binarized word, bit i = lane i
//   hv_addr       word index of the head
//   hv_last       head is the final word of the sample
//   hv_ones       running count of 1 bits in words pushed this sample
//   hv_done       one-cycle pulse when the sample is fully drained
//   busy          high while collecting or draining
//   err_overflow  sticky, a word was dropped because the FIFO was full
//   err_extra     sticky, sums_valid arrived while not collecting
// ---------------------------------------------------------------------------
module hv_binarize_collector #(
    parameter int NUM_LANES         = 16,
    parameter int ACC_WIDTH         = 16,
    parameter int NUM_WORDS         = 250,
    parameter int ADDR_WIDTH        = 8,
    parameter int FIFO_DEPTH        = 4,
    parameter int signed THRESH     = 0
) (
    input  logic                           clk,
    input  logic                           reset_in,
    input  logic                           start,
    input  logic                           sums_valid,
    input  logic [NUM_LANES*ACC_WIDTH-1:0] lane_sums,
    output logic                           hv_valid,
    input  logic                           hv_ready,
    output logic [NUM_LANES-1:0]           hv_data,
    output logic [ADDR_WIDTH-1:0]          hv_addr,
    output logic                           hv_last,
    output logic [11:0]                    hv_ones,
    output logic                           hv_done,
    output logic                           busy,
    output logic                           err_overflow,
    output logic                           err_extra
);

    import hd_pkg::*;

    localparam int EntryW = NUM_LANES + ADDR_WIDTH + 1;
    localparam int PcW    = $clog2(NUM_LANES + 1);
    localparam logic signed [ACC_WIDTH-1:0] ThreshS  = ACC_WIDTH'(THRESH);
    localparam logic [ADDR_WIDTH-1:0]       LastAddr = ADDR_WIDTH'(NUM_WORDS - 1);

    collector_state_t        state_q, state_d;
    logic [ADDR_WIDTH-1:0]   wordCnt_q, wordCnt_d;
    logic [11:0]             hvOnes_q, hvOnes_d;
    logic                    errOverflow_q, errOverflow_d;
    logic                    errExtra_q, errExtra_d;
    logic                    done_q, done_d;

    logic [NUM_LANES-1:0]    binWord;
    logic [PcW-1:0]          popCnt;
    logic                    pushReq, flushReq, hvPop, pushOk;
    logic                    fifoFull, fifoEmpty;
    logic [EntryW-1:0]       fifoWdata, fifoRdata;

    // Sign-binarize every lane and count the resulting ones in one pass.
    always_comb begin
        binWord = '0;
        popCnt  = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            binWord[i] = ($signed(lane_sums[i*ACC_WIDTH +: ACC_WIDTH]) >= ThreshS);
            popCnt     = popCnt + PcW'(binWord[i]);
        end
    end

    assign hvPop     = !fifoEmpty && hv_ready;
    assign pushOk    = !fifoFull || hvPop;
    assign fifoWdata = {binWord, wordCnt_q, (wordCnt_q == LastAddr)};

    // Sample control. start wins over everything in every state and silently
    // swallows a coincident sums_valid. A dropped word still advances the
    // address so that later words land at their true positions.
    always_comb begin
        state_d       = state_q;
        wordCnt_d     = wordCnt_q;
        hvOnes_d      = hvOnes_q;
        errOverflow_d = errOverflow_q;
        errExtra_d    = errExtra_q;
        done_d        = 1'b0;
        pushReq       = 1'b0;
        flushReq      = 1'b0;

        if (start) begin
            state_d       = COLLECT;
            wordCnt_d     = '0;
            hvOnes_d      = '0;
            errOverflow_d = 1'b0;
            errExtra_d    = 1'b0;
            flushReq      = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sums_valid) errExtra_d = 1'b1;
                end
                COLLECT: begin
                    if (sums_valid) begin
                        pushReq   = 1'b1;
                        wordCnt_d = wordCnt_q + 1'b1;
                        if (pushOk) hvOnes_d      = hvOnes_q + 12'(popCnt);
                        else        errOverflow_d = 1'b1;
                        if (wordCnt_q == LastAddr) state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    if (sums_valid) errExtra_d = 1'b1;
                    if (fifoEmpty) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State registers; reset discards the sample without a done pulse.
    always_ff @(posedge clk) begin
        if (reset_in) begin
            state_q       <= IDLE;
            wordCnt_q     <= '0;
            hvOnes_q      <= '0;
            errOverflow_q <= 1'b0;
            errExtra_q    <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            wordCnt_q     <= wordCnt_d;
            hvOnes_q      <= hvOnes_d;
            errOverflow_q <= errOverflow_d;
            errExtra_q    <= errExtra_d;
            done_q        <= done_d;
        end
    end

    hv_sync_fifo #(
        .WIDTH (EntryW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset_in (reset_in),
        .flush_i  (flushReq),
        .push_i   (pushReq),
        .wdata_i  (fifoWdata),
        .pop_i    (hvPop),
        .rdata_o  (fifoRdata),
        .full_o   (fifoFull),
        .empty_o  (fifoEmpty)
    );

    // Head fields are forced to zero while empty so unwritten storage never
    // leaks onto the outputs.
    assign hv_valid     = !fifoEmpty;
    assign hv_data      = fifoEmpty ? '0 : fifoRdata[EntryW-1 -: NUM_LANES];
    assign hv_addr      = fifoEmpty ? '0 : fifoRdata[ADDR_WIDTH:1];
    assign hv_last      = fifoEmpty ? 1'b0 : fifoRdata[0];
    assign hv_ones      = hvOnes_q;
    assign hv_done      = done_q;
    assign busy         = (state_q != IDLE);
    assign err_overflow = errOverflow_q;
    assign err_extra    = errExtra_q;

endmodule

// File: tb/tb_hv_binarize_collector.sv
// ---------------------------------------------------------------------------
// tb_hv_binarize_collector
// Directed testbench for the binarize collector: full sample, lane boundary
// values, overflow, full-FIFO push with pop, restart and reset in drain.
// ---------------------------------------------------------------------------
module tb_hv_binarize_collector;

    logic         clk = 1'b0;
    logic         reset_in = 1'b0;
    logic         start = 1'b0;
    logic         sums_valid = 1'b0;
    logic [255:0] lane_sums = '0;
    logic         hv_valid;
    logic         hv_ready = 1'b0;
    logic [15:0]  hv_data;
    logic [7:0]   hv_addr;
    logic         hv_last;
    logic [11:0]  hv_ones;
    logic         hv_done;
    logic         busy;
    logic         err_overflow;
    logic         err_extra;

    int assertCount = 0;
    int failCount   = 0;
    int doneCount   = 0;

    hv_binarize_collector dut (
        .clk          (clk),
        .reset_in     (reset_in),
        .start        (start),
        .sums_valid   (sums_valid),
        .lane_sums    (lane_sums),
        .hv_valid     (hv_valid),
        .hv_ready     (hv_ready),
        .hv_data      (hv_data),
        .hv_addr      (hv_addr),
        .hv_last      (hv_last),
        .hv_ones      (hv_ones),
        .hv_done      (hv_done),
        .busy         (busy),
        .err_overflow (err_overflow),
        .err_extra    (err_extra)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Count every done pulse seen by the design's clock
    always @(posedge clk) begin
        if (hv_done === 1'b1) doneCount <= doneCount + 1;
    end

    // Advance one edge and sample 1 ns after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // All even lanes = evenVal, all odd lanes = oddVal
    function automatic logic [255:0] makeLanes(input int evenVal, input int oddVal);
        logic [255:0] v;
        v = '0;
        for (int j = 0; j < 16; j++) v[j*16 +: 16] = (j % 2 == 0) ? 16'(evenVal) : 16'(oddVal);
        return v;
    endfunction

    // Lane k = +1, all others = -1: binarizes to a one-hot word (bit k)
    function automatic logic [255:0] makeOneHot(input int k);
        logic [255:0] v;
        v = '0;
        for (int j = 0; j < 16; j++) v[j*16 +: 16] = (j == k) ? 16'sd1 : -16'sd1;
        return v;
    endfunction

    // One sums_valid pulse carrying the given lanes
    task automatic applyStimulus(input logic [255:0] lanes);
        lane_sums  = lanes;
        sums_valid = 1'b1;
        tick();
        sums_valid = 1'b0;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic doReset();
        start      = 1'b0;
        sums_valid = 1'b0;
        hv_ready   = 1'b0;
        reset_in   = 1'b1;
        tick();
        tick();
        reset_in   = 1'b0;
    endtask

    task automatic test_reset();
        doReset();
        assertCount++;
        if (hv_valid !== 1'b0) begin failCount++; $display("[TB] FAIL reset_valid: got %b expected 0", hv_valid); end
        assertCount++;
        if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        assertCount++;
        if (hv_ones !== 12'd0) begin failCount++; $display("[TB] FAIL reset_ones: got %0d expected 0", hv_ones); end
        assertCount++;
        if ({hv_done, err_overflow, err_extra, hv_last} !== 4'b0000) begin
            failCount++; $display("[TB] FAIL reset_flags: got %b expected 0000", {hv_done, err_overflow, err_extra, hv_last});
        end
        assertCount++;
        if ({hv_data, hv_addr} !== 24'h0) begin failCount++; $display("[TB] FAIL reset_head: got %h expected 000000", {hv_data, hv_addr}); end
    endtask

    task automatic test_full_sample();
        int doneBase;
        doReset();
        hv_ready = 1'b1;
        pulseStart();
        assertCount++;
        if (busy !== 1'b1) begin failCount++; $display("[TB] FAIL full_busy_start: got %b expected 1", busy); end
        doneBase = doneCount;
        for (int w = 0; w < 250; w++) begin
            applyStimulus(makeLanes(5, -5));
            assertCount++;
            if ({hv_valid, hv_data, hv_addr, hv_last} !== {1'b1, 16'h5555, 8'(w), (w == 249)}) begin
                failCount++;
                $display("[TB] FAIL full_word%0d: got v=%b d=%h a=%0d l=%b expected v=1 d=5555 a=%0d l=%b",
                         w, hv_valid, hv_data, hv_addr, hv_last, w, (w == 249));
            end
            repeat (32) tick();
        end
        assertCount++;
        if (doneCount - doneBase !== 1) begin failCount++; $display("[TB] FAIL full_done_count: got %0d expected 1", doneCount - doneBase); end
        assertCount++;
        if (hv_ones !== 12'd2000) begin failCount++; $display("[TB] FAIL full_ones: got %0d expected 2000", hv_ones); end
        assertCount++;
        if ({err_overflow, err_extra, busy, hv_valid} !== 4'b0000) begin
            failCount++; $display("[TB] FAIL full_end_flags: got %b expected 0000", {err_overflow, err_extra, busy, hv_valid});
        end
    endtask

    task automatic test_boundary();
        logic [255:0] v;
        doReset();
        pulseStart();
        // lanes 0..3: 0, -1, 32767, -32768; lanes 4..7: +1; lanes 8..15: -2
        v = '0;
        v[0*16 +: 16] = 16'h0000;
        v[1*16 +: 16] = 16'hFFFF;
        v[2*16 +: 16] = 16'h7FFF;
        v[3*16 +: 16] = 16'h8000;
        for (int j = 4; j < 8; j++)  v[j*16 +: 16] = 16'h0001;
        for (int j = 8; j < 16; j++) v[j*16 +: 16] = 16'hFFFE;
        assertCount++;
        if (hv_valid !== 1'b0) begin failCount++; $display("[TB] FAIL bound_valid_before: got %b expected 0", hv_valid); end
        applyStimulus(v);
        assertCount++;
        if (hv_valid !== 1'b1) begin failCount++; $display("[TB] FAIL bound_latency: got %b expected 1", hv_valid); end
        assertCount++;
        if (hv_data !== 16'h00F5) begin failCount++; $display("[TB] FAIL bound_data: got %h expected 00f5", hv_data); end
        assertCount++;
        if (hv_ones !== 12'd6) begin failCount++; $display("[TB] FAIL bound_ones: got %0d expected 6", hv_ones); end
        tick();
        assertCount++;
        if ({hv_valid, hv_data} !== {1'b1, 16'h00F5}) begin failCount++; $display("[TB] FAIL bound_hold: got %b %h expected 1 00f5", hv_valid, hv_data); end
        hv_ready = 1'b1;
        tick();
        hv_ready = 1'b0;
        assertCount++;
        if (hv_valid !== 1'b0) begin failCount++; $display("[TB] FAIL bound_pop: got %b expected 0", hv_valid); end
    endtask

    task automatic test_overflow();
        doReset();
        pulseStart();
        for (int k = 0; k < 6; k++) applyStimulus(makeOneHot(k));
        assertCount++;
        if (err_overflow !== 1'b1) begin failCount++; $display("[TB] FAIL ovf_flag: got %b expected 1", err_overflow); end
        assertCount++;
        if (hv_ones !== 12'd4) begin failCount++; $display("[TB] FAIL ovf_ones: got %0d expected 4", hv_ones); end
        hv_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            assertCount++;
            if ({hv_valid, hv_addr, hv_data} !== {1'b1, 8'(k), 16'(1 << k)}) begin
                failCount++;
                $display("[TB] FAIL ovf_word%0d: got v=%b a=%0d d=%h expected v=1 a=%0d d=%h", k, hv_valid, hv_addr, hv_data, k, 16'(1 << k));
            end
            tick();
        end
        assertCount++;
        if (hv_valid !== 1'b0) begin failCount++; $display("[TB] FAIL ovf_empty: got %b expected 0", hv_valid); end
        applyStimulus(makeOneHot(6));
        assertCount++;
        if ({hv_addr, hv_data} !== {8'd6, 16'h0040}) begin failCount++; $display("[TB] FAIL ovf_next_addr: got a=%0d d=%h expected a=6 d=0040", hv_addr, hv_data); end
        assertCount++;
        if (hv_ones !== 12'd5) begin failCount++; $display("[TB] FAIL ovf_ones_after: got %0d expected 5", hv_ones); end
        hv_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        doReset();
        pulseStart();
        for (int k = 0; k < 4; k++) applyStimulus(makeOneHot(k));
        hv_ready = 1'b1;
        applyStimulus(makeOneHot(4));
        hv_ready = 1'b0;
        assertCount++;
        if (err_overflow !== 1'b0) begin failCount++; $display("[TB] FAIL b2b_overflow: got %b expected 0", err_overflow); end
        assertCount++;
        if (hv_ones !== 12'd5) begin failCount++; $display("[TB] FAIL b2b_ones: got %0d expected 5", hv_ones); end
        hv_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            assertCount++;
            if ({hv_valid, hv_addr, hv_data} !== {1'b1, 8'(k), 16'(1 << k)}) begin
                failCount++;
                $display("[TB] FAIL b2b_word%0d: got v=%b a=%0d d=%h expected v=1 a=%0d d=%h", k, hv_valid, hv_addr, hv_data, k, 16'(1 << k));
            end
            tick();
        end
        assertCount++;
        if (hv_valid !== 1'b0) begin failCount++; $display("[TB] FAIL b2b_empty: got %b expected 0", hv_valid); end
        hv_ready = 1'b0;
    endtask

    task automatic test_restart();
        int doneBase;
        doReset();
        applyStimulus(makeLanes(5, 5));
        assertCount++;
        if ({err_extra, busy, hv_valid} !== 3'b100) begin failCount++; $display("[TB] FAIL rst_idle_extra: got %b expected 100", {err_extra, busy, hv_valid}); end
        pulseStart();
        assertCount++;
        if ({err_extra, busy} !== 2'b01) begin failCount++; $display("[TB] FAIL rst_start_clear: got %b expected 01", {err_extra, busy}); end
        doneBase = doneCount;
        hv_ready = 1'b1;
        for (int w = 0; w < 100; w++) applyStimulus(makeLanes(5, 5));
        tick();
        assertCount++;
        if ({hv_valid, hv_ones} !== {1'b0, 12'd1600}) begin failCount++; $display("[TB] FAIL rst_100_words: got v=%b ones=%0d expected v=0 ones=1600", hv_valid, hv_ones); end
        hv_ready = 1'b0;
        applyStimulus(makeLanes(5, 5));
        applyStimulus(makeLanes(5, 5));
        assertCount++;
        if ({hv_valid, hv_addr} !== {1'b1, 8'd100}) begin failCount++; $display("[TB] FAIL rst_head: got v=%b a=%0d expected v=1 a=100", hv_valid, hv_addr); end
        start      = 1'b1;
        sums_valid = 1'b1;
        tick();
        start      = 1'b0;
        sums_valid = 1'b0;
        assertCount++;
        if ({hv_valid, busy, err_extra, err_overflow} !== 4'b0100) begin
            failCount++; $display("[TB] FAIL rst_flush: got %b expected 0100", {hv_valid, busy, err_extra, err_overflow});
        end
        assertCount++;
        if (hv_ones !== 12'd0) begin failCount++; $display("[TB] FAIL rst_ones_clear: got %0d expected 0", hv_ones); end
        applyStimulus(makeLanes(5, 5));
        assertCount++;
        if ({hv_valid, hv_addr, hv_data, hv_ones} !== {1'b1, 8'd0, 16'hFFFF, 12'd16}) begin
            failCount++; $display("[TB] FAIL rst_first_word: got v=%b a=%0d d=%h ones=%0d expected v=1 a=0 d=ffff ones=16", hv_valid, hv_addr, hv_data, hv_ones);
        end
        assertCount++;
        if (doneCount - doneBase !== 0) begin failCount++; $display("[TB] FAIL rst_no_done: got %0d expected 0", doneCount - doneBase); end
    endtask

    task automatic test_reset_in_drain();
        int doneBase;
        doReset();
        pulseStart();
        doneBase = doneCount;
        hv_ready = 1'b1;
        for (int w = 0; w < 247; w++) applyStimulus(makeLanes(5, -5));
        tick();
        hv_ready = 1'b0;
        for (int w = 247; w < 250; w++) applyStimulus(makeLanes(5, -5));
        assertCount++;
        if ({busy, hv_valid, hv_addr} !== {2'b11, 8'd247}) begin failCount++; $display("[TB] FAIL drain_setup: got b=%b v=%b a=%0d expected b=1 v=1 a=247", busy, hv_valid, hv_addr); end
        assertCount++;
        if (hv_ones !== 12'd2000) begin failCount++; $display("[TB] FAIL drain_ones: got %0d expected 2000", hv_ones); end
        reset_in = 1'b1;
        tick();
        reset_in = 1'b0;
        assertCount++;
        if ({hv_valid, busy, hv_done} !== 3'b000) begin failCount++; $display("[TB] FAIL drain_reset: got %b expected 000", {hv_valid, busy, hv_done}); end
        assertCount++;
        if (hv_ones !== 12'd0) begin failCount++; $display("[TB] FAIL drain_reset_ones: got %0d expected 0", hv_ones); end
        repeat (3) tick();
        assertCount++;
        if (doneCount - doneBase !== 0) begin failCount++; $display("[TB] FAIL drain_no_done: got %0d expected 0", doneCount - doneBase); end
    endtask

    initial begin
        #1;
        test_reset();
        test_full_sample();
        test_boundary();
        test_overflow();
        test_back_to_back();
        test_restart();
        test_reset_in_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
